i2c_slave_ctrl: RTL and testbench

Byte-level I2C slave protocol controller. It synchronises and deglitches the raw SCL/SDA pins, detects START/STOP, and matches the 7-bit address. It then sequences write and read transfers, raising ACKs and handing bytes to and from the register-file side through single-cycle strobes. It sits between the pad buffers and the slave register bank and is the only block that drives the SDA open-drain enable.

---
 rtl/i2c_slave_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C slave: pin conditioning, START/STOP detection, address match,
// and write/read byte sequencing towards the register bank.
module i2c_slave_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         SYNC_LEN   = 2,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic [2:0] state_dbg
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT
    } state_t;

    logic [SYNC_LEN-1:0] scl_sync, sda_sync;
    logic [FCW-1:0]      scl_cnt, sda_cnt;
    logic                scl_f, sda_f, scl_d, sda_d;
    logic                scl_s, sda_s;

    assign scl_s = scl_sync[SYNC_LEN-1];
    assign sda_s = sda_sync[SYNC_LEN-1];

    // The filtered line follows the synchroniser only after FILTER_LEN equal
    // differing samples; any sample matching the current value restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_LEN-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_LEN-2:0], sda_i};
            scl_d    <= scl_f;
            sda_d    <= sda_f;
            if (scl_s == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FCW'(FILTER_LEN - 1)) begin
                scl_f   <= scl_s;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + FCW'(1);
            end
            if (sda_s == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FCW'(FILTER_LEN - 1)) begin
                sda_f   <= sda_s;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + FCW'(1);
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & ~sda_f & sda_d;
    assign stop_det  = scl_f & scl_d & sda_f & ~sda_d;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [6:0] shreg, shreg_nxt;
    logic       rw, rw_nxt;
    logic       oe_nxt, busy_nxt, rx_valid_nxt;
    logic [7:0] rx_data_nxt;
    logic       tx_load, tx_load_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            tx_load  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            rw       <= rw_nxt;
            sda_oe   <= oe_nxt;
            busy     <= busy_nxt;
            rx_valid <= rx_valid_nxt;
            rx_data  <= rx_data_nxt;
            tx_load  <= tx_load_nxt;
        end
    end

    // Register-bank strobes carry no back-pressure: rx_valid qualifies rx_data for
    // exactly one cycle, and tx_req demands tx_data be valid the following cycle.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        rw_nxt       = rw;
        oe_nxt       = sda_oe;
        busy_nxt     = busy;
        rx_valid_nxt = 1'b0;
        rx_data_nxt  = rx_data;
        tx_load_nxt  = 1'b0;
        tx_req       = 1'b0;
        if (start_det) begin
            state_nxt   = S_ADDR;
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b0;
            busy_nxt    = 1'b0;
        end else if (stop_det) begin
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[5:0], sda_f};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rw_nxt      = sda_f;
                            bit_cnt_nxt = '0;
                            if (shreg == SLAVE_ADDR) begin
                                busy_nxt  = 1'b1;
                                state_nxt = S_ADDR_ACK;
                            end else begin
                                state_nxt = S_WAIT;
                            end
                        end
                    end
                end
                // First fall drives the ACK, the second ends the ninth clock.
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            oe_nxt      = 1'b1;
                            bit_cnt_nxt = 4'd1;
                        end else begin
                            oe_nxt      = 1'b0;
                            bit_cnt_nxt = '0;
                            if (state == S_ADDR_ACK && rw) begin
                                tx_req      = 1'b1;
                                tx_load_nxt = 1'b1;
                                state_nxt   = S_RD;
                            end else begin
                                state_nxt = S_WR;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[5:0], sda_f};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rx_data_nxt  = {shreg, sda_f};
                            rx_valid_nxt = 1'b1;
                            bit_cnt_nxt  = '0;
                            state_nxt    = S_WR_ACK;
                        end
                    end
                end
                S_RD: begin
                    if (tx_load) begin
                        shreg_nxt   = tx_data[6:0];
                        oe_nxt      = ~tx_data[7];
                        bit_cnt_nxt = '0;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            oe_nxt      = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = S_RD_ACK;
                        end else begin
                            oe_nxt      = ~shreg[6];
                            shreg_nxt   = {shreg[5:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                // bit_cnt=1 records that the master acknowledged on this ninth clock.
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            bit_cnt_nxt = 4'd1;
                        end else begin
                            oe_nxt    = 1'b0;
                            state_nxt = S_WAIT;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt_nxt = '0;
                        tx_req      = 1'b1;
                        tx_load_nxt = 1'b1;
                        state_nxt   = S_RD;
                    end
                end
                S_IDLE, S_WAIT: begin
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bit-banged I2C master, protocol-level expectations,
// randomized payloads and addresses.
module tb_i2c_slave_ctrl;

    localparam int Q   = 10;
    localparam int LAT = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl, m_sda;
    logic       sda_line;
    logic       sda_oe, busy, rx_valid, tx_req;
    logic [7:0] rx_data, tx_data;
    logic [2:0] state_dbg;

    assign sda_line = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_ctrl dut (
        .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda_line),
        .sda_oe(sda_oe), .busy(busy), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_req(tx_req), .tx_data(tx_data), .state_dbg(state_dbg)
    );

    int checks = 0, failures = 0;
    int rx_cnt = 0, tx_cnt = 0, oe_cnt = 0;
    logic [7:0] rx_log [0:63];
    logic [7:0] tx_tbl [0:3];
    logic [7:0] wbuf [0:3];
    logic [7:0] exp_q [$];
    int tx_base = 0;

    always @(posedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[5:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    assign tx_data = tx_tbl[2'(tx_cnt - tx_base - 1)];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_hit(input logic [7:0] a);
        return a[7:1] == 7'h50;
    endfunction

    task automatic bit_xfer(input logic b, output logic s);
        tick(Q); m_sda = b; tick(Q); m_scl = 1'b1; tick(Q); s = sda_line; tick(Q); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0;
    endtask

    task automatic i2c_stop(output int lat);
        tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1;
        lat = -1;
        for (int n = 1; n <= 2 * Q; n++) begin
            tick(1);
            if (lat < 0 && !busy) lat = n;
        end
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(ack_bit, s);
    endtask

    task automatic finish_stop(input string tag, input bit hit);
        int lat;
        chk({tag, "_busy_pre_stop"}, busy, hit);
        i2c_stop(lat);
        if (hit) chk({tag, "_busy_stop_lat"}, lat, LAT + 1);
        chk({tag, "_busy_post_stop"}, busy, 0);
    endtask

    task automatic write_txn(input string tag, input logic [7:0] addr, input int n,
                             input bit send_stop);
        logic ack;
        int rx0, tx0, oe0;
        bit hit;
        hit = addr_hit(addr) && !addr[0];
        rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cnt;
        exp_q.delete();
        i2c_start();
        write_byte(addr, ack);
        chk({tag, "_addr_ack"}, ack, hit ? 0 : 1);
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack);
            chk({tag, "_data_ack"}, ack, hit ? 0 : 1);
            if (hit) exp_q.push_back(wbuf[i]);
        end
        tick(2);
        chk({tag, "_rx_count"}, rx_cnt - rx0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, "_rx_byte"}, rx_log[6'(rx0 + i)], exp_q[i]);
        chk({tag, "_tx_req_none"}, tx_cnt - tx0, 0);
        if (!hit) chk({tag, "_no_drive"}, oe_cnt - oe0, 0);
        if (send_stop) finish_stop(tag, hit);
    endtask

    task automatic read_txn(input string tag, input logic [7:0] addr, input int n);
        logic ack;
        logic [7:0] d;
        int tx0;
        bit hit;
        hit = addr_hit(addr) && addr[0];
        tx_base = tx_cnt;
        tx0 = tx_cnt;
        i2c_start();
        write_byte(addr, ack);
        chk({tag, "_addr_ack"}, ack, hit ? 0 : 1);
        for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
            chk({tag, "_rd_byte"}, d, hit ? tx_tbl[i] : 8'hFF);
        end
        tick(2);
        chk({tag, "_tx_req_count"}, tx_cnt - tx0, hit ? n : 0);
        chk({tag, "_released"}, sda_oe, 0);
        finish_stop(tag, hit);
    endtask

    initial begin
        logic       ack, seen;
        logic [2:0] st_a, st_b;
        logic [6:0] a7;
        logic [7:0] gbyte;
        int         rx0, n;
        bit         hit, rw;

        m_scl = 1'b1; m_sda = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin tx_tbl[i] = 8'h00; wbuf[i] = 8'h00; end
        tick(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tx_req", tx_req, 0);
        rst_n = 1'b1;
        tick(10);

        wbuf[0] = 8'h3C; wbuf[1] = 8'hFF;
        write_txn("wr", 8'hA0, 2, 1'b1);
        chk("wr_rx_hold", rx_data, 8'hFF);

        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        write_txn("mis", 8'hA2, 2, 1'b1);

        tx_tbl[0] = 8'h96; tx_tbl[1] = 8'h5A;
        read_txn("rd", 8'hA1, 2);

        wbuf[0] = 8'($urandom);
        write_txn("rs_wr", 8'hA0, 1, 1'b0);
        tx_tbl[0] = 8'($urandom);
        read_txn("rs_rd", 8'hA1, 1);

        for (int it = 0; it < 6; it++) begin
            hit = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 3);
            a7  = 7'h50;
            if (!hit) begin
                a7 = 7'($urandom_range(0, 127));
                while (a7 == 7'h50) a7 = 7'($urandom_range(0, 127));
            end
            for (int i = 0; i < 4; i++) begin
                wbuf[i] = 8'($urandom); tx_tbl[i] = 8'($urandom);
            end
            if (rw) read_txn("rnd_rd", {a7, 1'b1}, n);
            else    write_txn("rnd_wr", {a7, 1'b0}, n, 1'b1);
        end

        st_a = state_dbg;
        tick(2); m_sda = 1'b0; tick(2); m_sda = 1'b1; tick(12);
        chk("idle_glitch_state", state_dbg, st_a);
        chk("idle_glitch_busy", busy, 0);

        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        chk("glitch_addr_ack", ack, 0);
        gbyte = {2'b10, 6'($urandom)};
        tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(4);
        st_a = state_dbg;
        m_sda = 1'b0; tick(2); m_sda = 1'b1; tick(2 * Q - 6); m_scl = 1'b0;
        tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(4);
        m_sda = 1'b1; tick(2); m_sda = 1'b0; tick(2 * Q - 6);
        st_b = state_dbg;
        m_scl = 1'b0;
        chk("glitch_state_kept", st_b, st_a);
        for (int i = 5; i >= 0; i--) bit_xfer(gbyte[i], seen);
        bit_xfer(1'b1, ack);
        chk("glitch_data_ack", ack, 0);
        tick(2);
        chk("glitch_rx_count", rx_cnt - rx0, 1);
        chk("glitch_rx_byte", rx_log[6'(rx0)], gbyte);
        finish_stop("glitch", 1'b1);

        tx_tbl[0] = 8'h00;
        tx_base = tx_cnt;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rst_mid_addr_ack", ack, 0);
        seen = 1'b0;
        for (int i = 0; i < 2 * Q && !seen; i++) begin
            tick(1);
            if (sda_oe) seen = 1'b1;
        end
        chk("rst_mid_driving", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async_release", sda_oe, 0);
        chk("rst_mid_busy", busy, 0);
        m_scl = 1'b1; m_sda = 1'b1;
        tick(10);
        rst_n = 1'b1;
        tick(10);
        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        write_txn("post_rst", 8'hA0, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
